// File: rtl/cpu_bus_master_if.sv
// -----------------------------------------------------------------------------
// cpu_bus_master_if
//   Groups the host request/response handshake and the Famicom cartridge CPU
//   bus pins driven by cpu_bus_master.
//
//   Host side : req_valid/req_ready/req_rw/req_addr/req_wdata,
//               resp_valid/resp_rdata, irq_pending
//   Cart side : m2, romsel, cpu_rw, cpu_addr, cpu_data_out, cpu_data_oe,
//               cpu_data_in, irq_n
//
//   master : the bus master block (drives the cartridge bus)
//   slave  : the environment around it (host plus cartridge)
// -----------------------------------------------------------------------------
interface cpu_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        m2;
    logic        romsel;
    logic        cpu_rw;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic [7:0]  cpu_data_in;
    logic        irq_n;
    logic        irq_pending;

    modport master (
        input  req_valid, req_rw, req_addr, req_wdata, cpu_data_in, irq_n,
        output req_ready, resp_valid, resp_rdata, m2, romsel, cpu_rw,
               cpu_addr, cpu_data_out, cpu_data_oe, irq_pending
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_wdata, cpu_data_in, irq_n,
        input  req_ready, resp_valid, resp_rdata, m2, romsel, cpu_rw,
               cpu_addr, cpu_data_out, cpu_data_oe, irq_pending
    );
endinterface

// File: rtl/cpu_bus_master.sv
// -----------------------------------------------------------------------------
// cpu_bus_master
//   Initiator for the Famicom cartridge CPU bus. Generates a free-running M2,
//   turns single-entry host requests into real bus cycles and synchronises the
//   cartridge /IRQ back to the host. M2 never stops: mapper logic counts it.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    cpu_bus_master_if.master
//              req_*        host request (one holding register)
//              resp_*       one-clk completion pulse + read data
//              m2/romsel/cpu_rw/cpu_addr/cpu_data_*  cartridge bus
//              irq_n -> irq_pending  synchronised interrupt
//
//   Phase FSM
//     state   | meaning
//     PH_LOW  | M2 low, M2_LOW_CLKS clks; address/R/W set up for the cycle
//     PH_HIGH | M2 high, M2_HIGH_CLKS clks; /ROMSEL and write data driven
// -----------------------------------------------------------------------------
module cpu_bus_master #(
    parameter int          M2_LOW_CLKS  = 5,
    parameter int          M2_HIGH_CLKS = 7,
    parameter logic [15:0] IDLE_ADDR    = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    cpu_bus_master_if.master   bus
);

    localparam int MAX_CLKS = (M2_LOW_CLKS > M2_HIGH_CLKS) ? M2_LOW_CLKS : M2_HIGH_CLKS;
    localparam int CNT_W    = $clog2(MAX_CLKS + 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(M2_LOW_CLKS - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(M2_HIGH_CLKS - 1);

    typedef enum logic {PH_LOW, PH_HIGH} phase_t;

    phase_t           state, state_nxt;
    logic [CNT_W-1:0] phase_cnt, phase_cnt_nxt;
    logic             lo_to_hi, hi_to_lo;

    // Holding register
    logic        pend_valid;
    logic        pend_rw;
    logic [15:0] pend_addr;
    logic [7:0]  pend_wdata;
    logic        ready_en;
    logic        accept;

    // Active bus cycle and registered outputs
    logic        act_req;
    logic        act_a15;
    logic        cpu_rw_q;
    logic [14:0] cpu_addr_q;
    logic [7:0]  data_out_q;
    logic        data_oe_q;
    logic        m2_q;
    logic        romsel_q;
    logic        resp_valid_q;
    logic [7:0]  resp_rdata_q;

    logic        irq_meta, irq_sync;

    // Phase timer: down-counter, terminal count at zero ends the phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PH_LOW;
            phase_cnt <= LOW_LOAD;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt - CNT_W'(1);
        lo_to_hi      = 1'b0;
        hi_to_lo      = 1'b0;
        unique case (state)
            PH_LOW: begin
                if (phase_cnt == '0) begin
                    state_nxt     = PH_HIGH;
                    phase_cnt_nxt = HIGH_LOAD;
                    lo_to_hi      = 1'b1;
                end
            end
            PH_HIGH: begin
                if (phase_cnt == '0) begin
                    state_nxt     = PH_LOW;
                    phase_cnt_nxt = LOW_LOAD;
                    hi_to_lo      = 1'b1;
                end
            end
            default: begin
                state_nxt     = PH_LOW;
                phase_cnt_nxt = LOW_LOAD;
            end
        endcase
    end

    // ready_en keeps req_ready low until the first edge after reset release
    assign accept = bus.req_valid & ready_en & ~pend_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            pend_valid <= 1'b0;
            pend_rw    <= 1'b1;
            pend_addr  <= '0;
            pend_wdata <= '0;
        end else begin
            ready_en <= 1'b1;
            // accept needs pend_valid=0, so it never races a launch; a request
            // taken on a launch edge waits for the next bus cycle
            if (accept) begin
                pend_valid <= 1'b1;
                pend_rw    <= bus.req_rw;
                pend_addr  <= bus.req_addr;
                pend_wdata <= bus.req_wdata;
            end else if (hi_to_lo) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // HIGH->LOW edge both completes the current cycle and launches the next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_req      <= 1'b0;
            act_a15      <= IDLE_ADDR[15];
            cpu_rw_q     <= 1'b1;
            cpu_addr_q   <= IDLE_ADDR[14:0];
            data_out_q   <= '0;
            data_oe_q    <= 1'b0;
            m2_q         <= 1'b0;
            romsel_q     <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            if (lo_to_hi) begin
                m2_q      <= 1'b1;
                romsel_q  <= ~act_a15;
                data_oe_q <= ~cpu_rw_q;
            end
            if (hi_to_lo) begin
                m2_q      <= 1'b0;
                romsel_q  <= 1'b1;
                data_oe_q <= 1'b0;
                if (act_req) begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= cpu_rw_q ? bus.cpu_data_in : 8'h00;
                end
                if (pend_valid) begin
                    act_req    <= 1'b1;
                    act_a15    <= pend_addr[15];
                    cpu_rw_q   <= pend_rw;
                    cpu_addr_q <= pend_addr[14:0];
                    data_out_q <= pend_rw ? 8'h00 : pend_wdata;
                end else begin
                    act_req    <= 1'b0;
                    act_a15    <= IDLE_ADDR[15];
                    cpu_rw_q   <= 1'b1;
                    cpu_addr_q <= IDLE_ADDR[14:0];
                    data_out_q <= 8'h00;
                end
            end
        end
    end

    // /IRQ synchroniser, idles high so irq_pending resets to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_meta <= 1'b1;
            irq_sync <= 1'b1;
        end else begin
            irq_meta <= bus.irq_n;
            irq_sync <= irq_meta;
        end
    end

    assign bus.req_ready    = ready_en & ~pend_valid;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.m2           = m2_q;
    assign bus.romsel       = romsel_q;
    assign bus.cpu_rw       = cpu_rw_q;
    assign bus.cpu_addr     = cpu_addr_q;
    assign bus.cpu_data_out = data_out_q;
    assign bus.cpu_data_oe  = data_oe_q;
    assign bus.irq_pending  = ~irq_sync;

endmodule
